pio_in_edge_irq: RTL and testbench

- Parametrised Avalon-MM input PIO slave for the SoC. Successor to the fixed 1-bit, read-only input port.
- Synchronises a WIDTH-bit external input bus and makes it readable over Avalon.
- Per-bit edge capture with write-1-to-clear, per-bit interrupt mask, and a registered interrupt request to the CPU.

---
 rtl/pio_in_edge_irq.sv | 114 +++++++++++
 tb/tb_pio_in_edge_irq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: per-bit synchroniser and edge capture (write-1-to-clear),
// interrupt mask, and registered irq/readdata.
module pio_in_edge_irq_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  input  logic clr,
  output logic data_in,
  output logic cap
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   data_prev;
  logic                   rise, fall, edge_det;

  assign data_in  = sync[SYNC_STAGES-1];
  assign rise     = data_in & ~data_prev;
  assign fall     = ~data_in & data_prev;
  assign edge_det = (EDGE_TYPE == 0) ? rise :
                    (EDGE_TYPE == 1) ? fall : (rise | fall);

  // A fresh edge outranks a same-cycle clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync      <= '0;
      data_prev <= 1'b0;
      cap       <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], in_bit};
      data_prev <= data_in;
      cap       <= edge_det | (cap & ~clr);
    end
  end
endmodule

module pio_in_edge_irq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_TYPE    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_EDGE = 2'd3;

  typedef struct packed {
    logic             wr;
    logic [1:0]       addr;
    logic [WIDTH-1:0] data;
  } bus_req_t;

  bus_req_t         req;
  logic [WIDTH-1:0] data_in, edge_cap, irq_mask, clr, irq_src;
  logic [31:0]      rd_next;

  assign req = '{wr: chipselect & ~write_n, addr: address, data: writedata[WIDTH-1:0]};
  assign clr = (req.wr && req.addr == A_EDGE) ? req.data : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    pio_in_edge_irq_lane #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_TYPE  (EDGE_TYPE)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .in_bit (in_port[i]),
      .clr    (clr[i]),
      .data_in(data_in[i]),
      .cap    (edge_cap[i])
    );
  end

  if (WIDTH < 32) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^writedata[31:WIDTH];
  end

  // Read path ignores chipselect: the mux is sampled every cycle.
  always_comb begin
    rd_next = '0;
    case (address)
      A_DATA:  rd_next[WIDTH-1:0] = data_in;
      A_MASK:  rd_next[WIDTH-1:0] = irq_mask;
      A_EDGE:  rd_next[WIDTH-1:0] = edge_cap;
      default: rd_next = '0;
    endcase
  end

  assign irq_src = (IRQ_TYPE == 0) ? data_in : edge_cap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (req.wr && req.addr == A_MASK) irq_mask <= req.data;
      readdata <= rd_next;
      irq      <= |(irq_src & irq_mask);
    end
  end
endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: two configurations checked every cycle against a
// history-queue model, plus directed literal expectations.
module tb_pio_in_edge_irq;
  localparam int WA = 8,  SA = 2, EA = 0, IA = 1;
  localparam int WB = 32, SB = 3, EB = 2, IB = 0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        cs_a = 1'b0, cs_b = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  int total = 0;
  int bad = 0;

  initial forever #5 clk = ~clk;

  pio_in_edge_irq #(.WIDTH(WA), .SYNC_STAGES(SA), .EDGE_TYPE(EA), .IRQ_TYPE(IA)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a));

  pio_in_edge_irq #(.WIDTH(WB), .SYNC_STAGES(SB), .EDGE_TYPE(EB), .IRQ_TYPE(IB)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b));

  // ---------------- behavioural model ----------------
  // m_hist[d][k] is the input as sampled k+1 clocks ago; data_in is the value
  // SYNC_STAGES samples back, data_prev one sample older still.
  logic [31:0] m_hist [2][5];
  logic [31:0] m_mask [2];
  logic [31:0] m_cap  [2];
  logic [31:0] m_rd   [2];
  logic        m_irq  [2];

  function automatic logic [31:0] wmask(int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  task automatic m_clear();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 5; k++) m_hist[d][k] = '0;
      m_mask[d] = '0; m_cap[d] = '0; m_rd[d] = '0; m_irq[d] = 1'b0;
    end
  endtask

  task automatic m_step(int d, int w, int s, int et, int it, logic cs, logic [31:0] pin);
    logic [31:0] wm, di, dp, ed, clr;
    logic we;
    wm = wmask(w);
    di = m_hist[d][s-1];
    dp = m_hist[d][s];
    if (et == 0)      ed = di & ~dp;
    else if (et == 1) ed = ~di & dp;
    else              ed = di ^ dp;
    case (address)
      2'd0:    m_rd[d] = di;
      2'd2:    m_rd[d] = m_mask[d];
      2'd3:    m_rd[d] = m_cap[d];
      default: m_rd[d] = '0;
    endcase
    m_irq[d] = |(((it == 0) ? di : m_cap[d]) & m_mask[d]);
    we  = cs && !write_n;
    clr = (we && address == 2'd3) ? (writedata & wm) : '0;
    m_cap[d] = (ed | (m_cap[d] & ~clr)) & wm;
    if (we && address == 2'd2) m_mask[d] = writedata & wm;
    for (int k = 4; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
    m_hist[d][0] = pin & wm;
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_clear();
      else begin
        m_step(0, WA, SA, EA, IA, cs_a, {24'd0, in_a});
        m_step(1, WB, SB, EB, IB, cs_b, in_b);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("mdl_rd_a",  rd_a,          m_rd[0]);
    chk("mdl_irq_a", {31'd0, irq_a}, {31'd0, m_irq[0]});
    chk("mdl_rd_b",  rd_b,          m_rd[1]);
    chk("mdl_irq_b", {31'd0, irq_b}, {31'd0, m_irq[1]});
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(bit b, logic [1:0] a, logic [31:0] d);
    address = a; writedata = d; write_n = 1'b0;
    cs_a = !b; cs_b = b;
    cyc(1);
    write_n = 1'b1; cs_a = 1'b0; cs_b = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk("rst_rd_a", rd_a, 32'h0);
    chk("rst_irq_a", {31'd0, irq_a}, 32'h0);
    chk("rst_rd_b", rd_b, 32'h0);
    chk("rst_irq_b", {31'd0, irq_b}, 32'h0);
    reset_n = 1'b1;
    cyc(2);

    // Data read latency: SYNC_STAGES+1 cycles
    address = 2'd0;
    in_a = 8'hA5; in_b = 32'h5A;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      if (k <= 3) chk("lat_a", rd_a, (k < 3) ? 32'h0 : 32'hA5);
      chk("lat_b", rd_b, (k < 4) ? 32'h0 : 32'h5A);
    end
    cyc(2);
    wr(0, 2'd3, 32'hFF);
    in_a = 8'h00; in_b = 32'h0;
    wr(1, 2'd3, 32'hFFFF_FFFF);
    cyc(5);
    wr(1, 2'd3, 32'hFFFF_FFFF);
    address = 2'd3;
    cyc(2);
    chk("clean_cap_a", rd_a, 32'h0);
    chk("clean_cap_b", rd_b, 32'h0);

    // Rising-edge capture and W1C
    in_a = 8'h08; cyc(4); in_a = 8'h00; cyc(4);
    chk("cap_rise", rd_a, 32'h08);
    wr(0, 2'd3, 32'h08); cyc(1);
    chk("w1c", rd_a, 32'h0);
    in_a = 8'h08; cyc(4);
    wr(0, 2'd3, 32'h08);
    in_a = 8'h00; cyc(5);
    chk("fall_only", rd_a, 32'h0);

    // Edge interrupt with mask and clear
    in_a = 8'h01; cyc(4);
    chk("irq_masked", {31'd0, irq_a}, 32'h0);
    chk("cap_bit0", rd_a, 32'h01);
    wr(0, 2'd2, 32'h01);
    chk("irq_pre", {31'd0, irq_a}, 32'h0);
    cyc(1);
    chk("irq_on", {31'd0, irq_a}, 32'h1);
    wr(0, 2'd3, 32'h01);
    chk("irq_hold", {31'd0, irq_a}, 32'h1);
    cyc(1);
    chk("irq_off", {31'd0, irq_a}, 32'h0);
    in_a = 8'h00;
    wr(0, 2'd2, 32'h0);
    address = 2'd3;
    cyc(3);

    // Clear of bit 2 in the cycle its rising edge is detected
    in_a = 8'h04; cyc(2);
    wr(0, 2'd3, 32'h04); cyc(1);
    chk("collide", rd_a, 32'h04);

    // Level interrupt and any-edge capture on the 32-bit instance
    wr(1, 2'd2, 32'h80);
    address = 2'd3;
    in_b = 32'h80;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk("lvl_rise", {31'd0, irq_b}, (k == 4) ? 32'h1 : 32'h0);
    end
    cyc(1);
    chk("cap_b_rise", rd_b, 32'h80);
    wr(1, 2'd3, 32'h80); cyc(1);
    chk("cap_b_clr", rd_b, 32'h0);
    in_b = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk("lvl_fall", {31'd0, irq_b}, (k < 4) ? 32'h1 : 32'h0);
    end
    cyc(1);
    chk("cap_b_fall", rd_b, 32'h80);

    // Reserved and read-only addresses
    wr(1, 2'd0, 32'hFFFF_FFFF);
    wr(1, 2'd1, 32'hFFFF_FFFF);
    address = 2'd1; cyc(1);
    chk("rsv_b", rd_b, 32'h0);
    address = 2'd0; cyc(1);
    chk("ro_b", rd_b, 32'h0);

    // Mask width: upper bits dropped on the narrow instance
    wr(1, 2'd2, 32'hFFFF_FFFF);
    wr(0, 2'd2, 32'hFFFF_FFFF);
    cyc(1);
    chk("mask32", rd_b, 32'hFFFF_FFFF);
    chk("mask8", rd_a, 32'h0000_00FF);

    // Mid-operation asynchronous reset
    in_a = 8'hFF; address = 2'd3;
    cyc(5);
    chk("pre_cap", rd_a, 32'hFF);
    chk("pre_irq", {31'd0, irq_a}, 32'h1);
    #2;
    reset_n = 1'b0; in_a = 8'h00; in_b = 32'h0;
    #1;
    chk("arst_rd_a", rd_a, 32'h0);
    chk("arst_irq_a", {31'd0, irq_a}, 32'h0);
    chk("arst_rd_b", rd_b, 32'h0);
    cyc(2);
    reset_n = 1'b1;
    address = 2'd2; cyc(1);
    chk("arst_mask", rd_a, 32'h0);
    address = 2'd3; cyc(1);
    chk("arst_cap", rd_a, 32'h0);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
